// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_dispatch start/busy core feeder.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int W_IN_DEF  = 32;
  localparam int W_OUT_DEF = 64;

  // Result returned when the watchdog abandons a job.
  localparam logic [W_OUT_DEF-1:0] ABORT_Y = '1;

endpackage

// File: rtl/calc_fifo.sv
// Synchronous operand FIFO; pointers carry an extra wrap bit so full/empty need no flag.
module calc_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 * W_IN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/calc_dispatch.sv
// Buffers operand pairs and runs a start/busy core one job at a time; results leave on valid/ready.
// Optional watchdog abort enabled by defining CALC_DISPATCH_WDT_EN.
//
// state     | meaning
// IDLE      | waiting for an operand pair and a free result slot
// WAIT_BUSY | launch issued, waiting for the core to raise busy
// RUN       | core busy, result captured when busy falls
module calc_dispatch
  import calc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int W_IN       = W_IN_DEF,
  parameter int W_OUT      = W_OUT_DEF,
  parameter int WDT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [W_IN-1:0]        in_a_bi,
  input  logic [W_IN-1:0]        in_b_bi,
  output logic                   core_start_o,
  output logic [W_IN-1:0]        core_a_bo,
  output logic [W_IN-1:0]        core_b_bo,
  input  logic                   core_busy_i,
  input  logic [W_OUT-1:0]       core_y_bi,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [W_OUT-1:0]       out_y_bo,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] pending_bo
);

  state_t              state;
  logic [2*W_IN-1:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                launch;

  assign in_ready_o = !fifo_full;
  // Launch only when the result slot is empty or being drained this cycle.
  assign launch = (state == IDLE) && !fifo_empty && (!out_valid_o || out_ready_i);

  calc_fifo #(.DEPTH(DEPTH), .W(2 * W_IN)) u_fifo (
    .clk   (clk_i),
    .rst_b (rst_i),
    .push  (in_valid_i),
    .wdata ({in_a_bi, in_b_bi}),
    .pop   (launch),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_bo)
  );

`ifdef CALC_DISPATCH_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_tc;
  assign wdt_tc = (wdt_cnt == '0);
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      core_start_o <= 1'b0;
      core_a_bo    <= '0;
      core_b_bo    <= '0;
      out_valid_o  <= 1'b0;
      out_y_bo     <= '0;
`ifdef CALC_DISPATCH_WDT_EN
      err_o        <= 1'b0;
      wdt_cnt      <= '0;
`endif
    end else begin
      core_start_o <= 1'b0;
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            {core_a_bo, core_b_bo} <= fifo_rdata;
            core_start_o           <= 1'b1;
            state                  <= WAIT_BUSY;
`ifdef CALC_DISPATCH_WDT_EN
            wdt_cnt                <= WDT_W'(WDT_CYCLES - 1);
`endif
          end
        end
        WAIT_BUSY: begin
          if (core_busy_i) state <= RUN;
`ifdef CALC_DISPATCH_WDT_EN
          if (wdt_tc) begin
            out_y_bo    <= W_OUT'(ABORT_Y);
            err_o       <= 1'b1;
            out_valid_o <= 1'b1;
            state       <= IDLE;
          end else begin
            wdt_cnt <= wdt_cnt - WDT_W'(1);
          end
`endif
        end
        RUN: begin
          if (!core_busy_i) begin
            out_y_bo    <= core_y_bi;
            out_valid_o <= 1'b1;
            state       <= IDLE;
`ifdef CALC_DISPATCH_WDT_EN
            err_o       <= 1'b0;
          end else if (wdt_tc) begin
            out_y_bo    <= W_OUT'(ABORT_Y);
            err_o       <= 1'b1;
            out_valid_o <= 1'b1;
            state       <= IDLE;
          end else begin
            wdt_cnt <= wdt_cnt - WDT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
